mio_bus_ctrl: RTL and testbench

- Memory/IO bus controller directly downstream of the multicycle CPU core.
- Consumes the CPU's access strobe, write flag, address and store data.
- Decodes each access to block RAM or on-chip peripherals (LED register, switches, cycle counter).
- Returns load data with a one-cycle ready pulse that releases the CPU's wait state.

---
 rtl/mio_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the multicycle CPU: block RAM, LED and switch
// registers, and a free-running cycle counter that exists only when `COUNTER_EN is defined.
module mio_bus_ctrl #(
    parameter int RAM_LAT = 1,
    parameter int RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_from_cpu,
    output logic              MIO_ready,
    output logic [31:0]       Data_to_cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;

    localparam logic [29:0] LED_WA    = 30'h3800_0000;
    localparam logic [29:0] SW_WA     = 30'h3C00_0000;
    localparam logic [2:0]  WAIT_INIT = 3'(RAM_LAT - 1);

    state_t            state_reg, state_next;
    logic [2:0]        wait_reg, wait_next;
    logic              is_load_reg, is_load_next;
    logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
    logic [31:0]       ram_din_reg, ram_din_next;
    logic              ram_we_reg, ram_we_next;
    logic [31:0]       dout_reg, dout_next;
    logic [15:0]       led_reg, led_next;
    logic              bus_err_reg, bus_err_next;

    logic [29:0]       word_addr;
    logic              is_ram, is_led, is_sw, is_cnt;
    logic [31:0]       cnt_val;
    logic [31:0]       rd_data;
    logic              unused_addr_bits;

    assign word_addr        = Addr_in[31:2];
    assign unused_addr_bits = ^Addr_in[1:0];
    assign is_ram           = (Addr_in[31:RAM_AW+2] == '0);
    assign is_led           = (word_addr == LED_WA);
    assign is_sw            = (word_addr == SW_WA);

`ifdef COUNTER_EN
    localparam logic [29:0] CNT_WA = 30'h3C00_0001;
    logic [31:0] cnt_reg, cnt_next;

    assign is_cnt  = (word_addr == CNT_WA);
    assign cnt_val = cnt_reg;

    // A CPU write landing on the same edge overrides the free-running increment.
    always_comb begin
        cnt_next = cnt_reg + 32'd1;
        if (state_reg == IDLE && CPU_MIO && mem_w && is_cnt)
            cnt_next = Data_from_cpu;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
    end
`else
    assign is_cnt  = 1'b0;
    assign cnt_val = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (is_led)      rd_data = {16'b0, led_reg};
        else if (is_sw)  rd_data = {16'b0, sw};
        else if (is_cnt) rd_data = cnt_val;
    end

    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        is_load_next  = is_load_reg;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;
        ram_we_next   = 1'b0;
        dout_next     = dout_reg;
        led_next      = led_reg;
        bus_err_next  = bus_err_reg;
        case (state_reg)
            IDLE: begin
                if (CPU_MIO) begin
                    if (is_ram) begin
                        ram_addr_next = Addr_in[RAM_AW+1:2];
                        ram_din_next  = Data_from_cpu;
                        ram_we_next   = mem_w;
                        is_load_next  = !mem_w;
                        wait_next     = WAIT_INIT;
                        state_next    = RAM_WAIT;
                    end else begin
                        // Peripherals complete on the request edge; unmapped stores are dropped.
                        if (mem_w) begin
                            if (is_led) led_next = Data_from_cpu[15:0];
                        end else begin
                            dout_next = rd_data;
                        end
                        if (!(is_led || is_sw || is_cnt)) bus_err_next = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            RAM_WAIT: begin
                if (wait_reg == 3'd0) begin
                    if (is_load_reg) dout_next = ram_dout;
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg - 3'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_reg     <= '0;
            is_load_reg  <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_we_reg   <= 1'b0;
            dout_reg     <= '0;
            led_reg      <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_reg     <= wait_next;
            is_load_reg  <= is_load_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
            ram_we_reg   <= ram_we_next;
            dout_reg     <= dout_next;
            led_reg      <= led_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    assign MIO_ready   = (state_reg == DONE);
    assign Data_to_cpu = dout_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_din     = ram_din_reg;
    assign ram_we      = ram_we_reg;
    assign led         = led_reg;
    assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: one instance with RAM_LAT=1, one with RAM_LAT=3,
// each backed by a behavioural BRAM model; expected load data flows through a scoreboard queue.
module tb_mio_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mio   [2];
    logic        mw    [2];
    logic [31:0] addr  [2];
    logic [31:0] dfc   [2];
    logic        rdy   [2];
    logic [31:0] dtc   [2];
    logic [9:0]  raddr [2];
    logic [31:0] din   [2];
    logic        we    [2];
    logic [31:0] dout  [2];
    logic [15:0] led_o [2];
    logic        berr  [2];
    logic [15:0] sw;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [31:0] p1, p2;
    int          rdy_cnt [2];
    int          we_cnt  [2];
    logic [9:0]  we_addr [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mio_bus_ctrl #(.RAM_LAT(1), .RAM_AW(10)) dut0 (
        .clk(clk), .reset(reset), .CPU_MIO(mio[0]), .mem_w(mw[0]), .Addr_in(addr[0]),
        .Data_from_cpu(dfc[0]), .MIO_ready(rdy[0]), .Data_to_cpu(dtc[0]), .ram_addr(raddr[0]),
        .ram_din(din[0]), .ram_we(we[0]), .ram_dout(dout[0]), .sw(sw), .led(led_o[0]),
        .bus_err(berr[0])
    );

    mio_bus_ctrl #(.RAM_LAT(3), .RAM_AW(10)) dut1 (
        .clk(clk), .reset(reset), .CPU_MIO(mio[1]), .mem_w(mw[1]), .Addr_in(addr[1]),
        .Data_from_cpu(dfc[1]), .MIO_ready(rdy[1]), .Data_to_cpu(dtc[1]), .ram_addr(raddr[1]),
        .ram_din(din[1]), .ram_we(we[1]), .ram_dout(dout[1]), .sw(sw), .led(led_o[1]),
        .bus_err(berr[1])
    );

    // BRAM models: data valid RAM_LAT-1 register stages after the registered address.
    assign dout[0] = mem0[raddr[0]];
    assign dout[1] = p2;

    always @(posedge clk) begin
        if (we[0]) mem0[raddr[0]] <= din[0];
        if (we[1]) mem1[raddr[1]] <= din[1];
        p1 <= mem1[raddr[1]];
        p2 <= p1;
        for (int i = 0; i < 2; i++) begin
            if (rdy[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
            if (we[i]) begin
                we_cnt[i]  <= we_cnt[i] + 1;
                we_addr[i] <= raddr[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access on instance s; latency counts edges from the request edge up to MIO_ready.
    task automatic acc(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_dtc, input string tag);
        int lat;
        int r0;
        exp_q.push_back(exp_dtc);
        @(posedge clk); #1;
        mio[s] = 1'b1; mw[s] = w; addr[s] = a; dfc[s] = d;
        r0  = rdy_cnt[s];
        lat = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (rdy[s]) begin
                lat = n;
                break;
            end
        end
        mio[s] = 1'b0; mw[s] = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, dtc[s], exp_q.pop_front());
        @(posedge clk); #1;
        check({tag, "_rdy_low"}, {31'b0, rdy[s]}, 32'd0);
        check({tag, "_pulses"}, 32'(rdy_cnt[s] - r0), 32'd1);
        $display("txn %s: inst=%0d we=%0b addr=%h latency=%0d data=%h", tag, s, w, a, lat, dtc[s]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, wc;
        reset = 1'b0;
        sw    = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            mio[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; dfc[i] = '0;
        end
        repeat (3) @(posedge clk); #1;
        check("rst_ready",    {31'b0, rdy[0]},  32'd0);
        check("rst_ram_we",   {31'b0, we[0]},   32'd0);
        check("rst_bus_err",  {31'b0, berr[0]}, 32'd0);
        check("rst_led",      {16'b0, led_o[0]}, 32'd0);
        check("rst_ram_addr", {22'b0, raddr[0]}, 32'd0);
        check("rst_ram_din",  din[0], 32'd0);
        check("rst_dtc",      dtc[0], 32'd0);
        check("rst_dtc_l3",   dtc[1], 32'd0);
        reset = 1'b1;

        // RAM_LAT=1 store then load.
        acc(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0, "ram_st");
        check("ram_we_pulses", 32'(we_cnt[0]), 32'd1);
        check("ram_we_addr",   {22'b0, we_addr[0]}, 32'd4);
        check("ram_din",       din[0], 32'hDEAD_BEEF);
        check("ram_we_low",    {31'b0, we[0]}, 32'd0);
        acc(0, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, "ram_ld");

        // Peripherals.
        acc(0, 1'b1, 32'hE000_0000, 32'h0000_A5A5, 1, 32'hDEAD_BEEF, "led_st");
        check("led_val", {16'b0, led_o[0]}, 32'h0000_A5A5);
        sw = 16'h1234;
        acc(0, 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0000_1234, "sw_ld");
        acc(0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 1, 32'h0000_1234, "sw_st");
        acc(0, 1'b0, 32'hE000_0000, 32'h0, 1, 32'h0000_A5A5, "led_ld");

`ifdef COUNTER_EN
        acc(0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1, 32'h0000_A5A5, "cnt_wr");
        repeat (2) @(posedge clk);
        acc(0, 1'b0, 32'hF000_0004, 32'h0, 1, 32'h0000_0002, "cnt_wrap");
        acc(0, 1'b1, 32'hF000_0004, 32'h1000_0000, 1, 32'h0000_0002, "cnt_wr2");
        acc(0, 1'b0, 32'hF000_0004, 32'h0, 1, 32'h1000_0002, "cnt_coll");
        check("cnt_no_err", {31'b0, berr[0]}, 32'd0);
`else
        check("pre_unmap_err", {31'b0, berr[0]}, 32'd0);
        acc(0, 1'b0, 32'hF000_0004, 32'h0, 1, 32'h0, "cnt_unmapped");
        check("cnt_unmap_err", {31'b0, berr[0]}, 32'd1);
`endif

        // Unmapped access: sticky error, zero data, store dropped.
        acc(0, 1'b0, 32'h8000_0000, 32'h0, 1, 32'h0, "unmap_ld");
        check("unmap_err", {31'b0, berr[0]}, 32'd1);
        acc(0, 1'b1, 32'h8000_0000, 32'h0000_5A5A, 1, 32'h0, "unmap_st");
        check("unmap_st_led", {16'b0, led_o[0]}, 32'h0000_A5A5);
        acc(0, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, "ram_ld2");
        acc(0, 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0000_1234, "sw_ld2");
        check("err_sticky", {31'b0, berr[0]}, 32'd1);

        // RAM_LAT=3 instance.
        acc(1, 1'b1, 32'h0000_0020, 32'h2468_ACE0, 4, 32'h0, "l3_st");
        check("l3_we_addr", {22'b0, we_addr[1]}, 32'd8);
        acc(1, 1'b0, 32'h0000_0020, 32'h0, 4, 32'h2468_ACE0, "l3_ld");
        r  = rdy_cnt[1];
        wc = we_cnt[1];
        repeat (6) @(posedge clk); #1;
        check("l3_idle_ready", 32'(rdy_cnt[1] - r), 32'd0);
        check("l3_idle_we",    32'(we_cnt[1] - wc), 32'd0);

        // Reset while in RAM_WAIT aborts the load.
        acc(1, 1'b1, 32'h0000_0024, 32'h1111_2222, 4, 32'h2468_ACE0, "l3_st2");
        @(posedge clk); #1;
        mio[1] = 1'b1; mw[1] = 1'b0; addr[1] = 32'h0000_0024;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mio[1] = 1'b0;
        #1;
        check("abort_ready", {31'b0, rdy[1]}, 32'd0);
        check("abort_we",    {31'b0, we[1]},  32'd0);
        check("abort_dtc",   dtc[1], 32'd0);
        r = rdy_cnt[1];
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("abort_no_pulse", 32'(rdy_cnt[1] - r), 32'd0);
        check("abort_discard",  dtc[1], 32'd0);
        acc(1, 1'b0, 32'h0000_0024, 32'h0, 4, 32'h1111_2222, "l3_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
